// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm: bit-serial adder/subtractor, one bit per clock, LSB first.
// A single full-adder slice with a registered carry walks across WIDTH-bit
// operands. Results appear only at completion together with carry-out and
// signed overflow.
//
// Handshake: start is sampled on a rising edge only while idle (busy=0);
// that edge accepts the operands and raises busy. start seen while busy=1 is
// dropped, not queued. WIDTH edges after the accept edge the result registers
// load, busy falls and done pulses high for one cycle. The done cycle is idle,
// so a start held high there is accepted immediately (back-to-back).
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift_a;
    logic [WIDTH-1:0] r_shift_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic             w_accept;
    logic             w_last;
    logic             w_bit;
    logic             w_carry_nxt;

    // Full-adder slice on the current LSBs and the registered carry.
    assign w_bit       = r_shift_a[0] ^ r_shift_b[0] ^ r_carry;
    assign w_carry_nxt = (r_shift_a[0] & r_shift_b[0]) |
                         (r_shift_a[0] & r_carry) |
                         (r_shift_b[0] & r_carry);
    assign w_last      = (r_count == LAST_BIT);

    assign busy      = (r_state == S_RUN);
    assign dbg_state = r_state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept only from IDLE, leave RUN after the MSB edge.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand load on accept, then shift one bit per RUN edge.
    // Subtraction is a + ~b + 1, so the inversion and the forced carry are
    // applied once at load time and the slice itself never knows the mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift_a <= '0;
            r_shift_b <= '0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_count   <= '0;
        end else if (w_accept) begin
            r_shift_a <= a;
            r_shift_b <= sub ? ~b : b;
            r_carry   <= sub ? 1'b1 : cin;
            r_count   <= '0;
        end else if (r_state == S_RUN) begin
            r_result  <= {w_bit, r_result[WIDTH-1:1]};
            r_shift_a <= r_shift_a >> 1;
            r_shift_b <= r_shift_b >> 1;
            r_carry   <= w_carry_nxt;
            r_count   <= r_count + CW'(1);
        end
    end

    // Output registers load only at completion, so partial sums never show.
    // On the MSB edge r_carry still holds the carry into the MSB, which is
    // what overflow compares against the carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((r_state == S_RUN) && w_last) begin
                sum      <= {w_bit, r_result[WIDTH-1:1]};
                cout     <= w_carry_nxt;
                overflow <= r_carry ^ w_carry_nxt;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Bench for serial_adder_fsm: an 8-bit instance for directed and random
// operations plus a 2-bit instance swept exhaustively.
module tb_serial_adder_fsm;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, overflow, dbg_state;
  logic [W-1:0] sum;

  // 2-bit instance
  logic       start2 = 1'b0;
  logic       sub2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2, done2, cout2, ovf2, dbg2;
  logic [1:0] sum2;

  serial_adder_fsm #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  serial_adder_fsm #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .cin(cin2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
    .overflow(ovf2), .dbg_state(dbg2)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [W+1:0] exp_q[$];

  // Reference: {overflow, cout, sum} from plain integer arithmetic.
  // Overflow uses the sign rule: both addends share a sign and the sum differs.
  function automatic logic [W+1:0] model(int w, int ia, int ib, int icin, int isub);
    int mask, bb, c0, tot, s, co, ov, sa, sb, ss, r;
    mask = (1 << w) - 1;
    bb   = isub != 0 ? (~ib & mask) : (ib & mask);
    c0   = isub != 0 ? 1 : (icin & 1);
    tot  = (ia & mask) + bb + c0;
    s    = tot & mask;
    co   = (tot >> w) & 1;
    sa   = ((ia & mask) >> (w - 1)) & 1;
    sb   = (bb >> (w - 1)) & 1;
    ss   = (s >> (w - 1)) & 1;
    ov   = (sa == sb && ss != sa) ? 1 : 0;
    r    = (ov << (w + 1)) | (co << w) | s;
    return r[W+1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic icin, input logic isub,
                        output logic [W+1:0] res, output int lat,
                        output logic busy1, output logic changed);
    logic [W+1:0] prev;
    int j;
    @(negedge clk);
    prev = {overflow, cout, sum};
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy1 = busy;
    changed = 1'b0;
    j = 1;
    while (done !== 1'b1 && j < 40) begin
      if ({overflow, cout, sum} !== prev) changed = 1'b1;
      @(negedge clk);
      j++;
    end
    lat = (done === 1'b1) ? j - 1 : -1;
    res = {overflow, cout, sum};
  endtask

  task automatic run_op2(input logic [1:0] ia, input logic [1:0] ib,
                         input logic icin, input logic isub,
                         output logic [3:0] res, output int lat);
    int j;
    @(negedge clk);
    a2 = ia; b2 = ib; cin2 = icin; sub2 = isub; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    j = 1;
    while (done2 !== 1'b1 && j < 20) begin
      @(negedge clk);
      j++;
    end
    lat = (done2 === 1'b1) ? j - 1 : -1;
    res = {ovf2, cout2, sum2};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; sub = 1'b0; cin = 1'b1;
    a = W'($urandom); b = W'($urandom);
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, sum, cout, overflow, dbg_state} !== '0) begin
      bad++;
      $display("FAIL reset_hold got=%h exp=0", {busy, done, sum, cout, overflow, dbg_state});
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if ({busy, done, sum, cout, overflow, dbg_state} !== '0) begin
      bad++;
      $display("FAIL reset_release got=%h exp=0", {busy, done, sum, cout, overflow, dbg_state});
    end
  endtask

  task automatic test_add_basic;
    logic [W+1:0] r; int lat; logic b1, ch;
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, r, lat, b1, ch);
    total++;
    if (lat !== 8) begin bad++; $display("FAIL add_latency got=%0d exp=8", lat); end
    total++;
    if (b1 !== 1'b1) begin bad++; $display("FAIL busy_after_accept got=%b exp=1", b1); end
    total++;
    if (r !== {1'b0, 1'b0, 8'h10}) begin bad++; $display("FAIL add_0f_01 got=%h exp=%h", r, {2'b00, 8'h10}); end
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, r, lat, b1, ch);
    total++;
    if (r !== {1'b0, 1'b1, 8'h01}) begin bad++; $display("FAIL add_ff_01_cin got=%h exp=%h", r, {2'b01, 8'h01}); end
  endtask

  task automatic test_overflow;
    logic [W+1:0] r; int lat; logic b1, ch;
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, r, lat, b1, ch);
    total++;
    if (r !== {1'b1, 1'b0, 8'h80}) begin bad++; $display("FAIL add_ovf got=%h exp=%h", r, {2'b10, 8'h80}); end
    run_op(8'h05, 8'h07, 1'b1, 1'b1, r, lat, b1, ch);
    total++;
    if (r !== {1'b0, 1'b0, 8'hFE}) begin bad++; $display("FAIL sub_borrow got=%h exp=%h", r, {2'b00, 8'hFE}); end
    run_op(8'h80, 8'h01, 1'b0, 1'b1, r, lat, b1, ch);
    total++;
    if (r !== {1'b1, 1'b1, 8'h7F}) begin bad++; $display("FAIL sub_ovf got=%h exp=%h", r, {2'b11, 8'h7F}); end
  endtask

  task automatic test_ignore_start;
    int ndone;
    logic [W+1:0] r;
    @(negedge clk);
    a = 8'h21; b = 8'h13; cin = 1'b0; sub = 1'b0; start = 1'b1;
    ndone = 0;
    r = '0;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        r = {overflow, cout, sum};
      end
      start = (j == 2 || j == 5);
      if (start) begin
        a = W'($urandom); b = W'($urandom); sub = 1'b1; cin = 1'b1;
      end
    end
    start = 1'b0;
    total++;
    if (ndone !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    total++;
    if (r !== {2'b00, 8'h34}) begin bad++; $display("FAIL ignore_result got=%h exp=%h", r, {2'b00, 8'h34}); end
  endtask

  task automatic test_back_to_back;
    int n, stable_bad;
    int pos[4];
    logic [W-1:0] val[4];
    @(negedge clk);
    a = 8'd1; b = 8'd2; cin = 1'b0; sub = 1'b0; start = 1'b1;
    n = 0;
    stable_bad = 0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (j == 1) begin a = 8'd3; b = 8'd4; end
      if (done === 1'b1) begin
        if (n < 4) begin pos[n] = j; val[n] = sum; end
        n++;
        if (n == 2) start = 1'b0;
      end else if (n == 1 && sum !== 8'd3) begin
        stable_bad++;
      end
    end
    start = 1'b0;
    total++;
    if (n !== 2) begin
      bad++; $display("FAIL b2b_done_count got=%0d exp=2", n);
    end else begin
      total++;
      if (pos[1] - pos[0] !== 9) begin bad++; $display("FAIL b2b_spacing got=%0d exp=9", pos[1] - pos[0]); end
      total++;
      if (val[0] !== 8'd3) begin bad++; $display("FAIL b2b_first got=%h exp=03", val[0]); end
      total++;
      if (val[1] !== 8'd7) begin bad++; $display("FAIL b2b_second got=%h exp=07", val[1]); end
    end
    total++;
    if (stable_bad !== 0) begin bad++; $display("FAIL b2b_sum_stable got=%0d exp=0", stable_bad); end
  endtask

  task automatic test_reset_mid_run;
    int ndone;
    @(negedge clk);
    a = 8'h55; b = 8'h22; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, sum, cout, overflow} !== '0) begin
      bad++; $display("FAIL abort_outputs got=%h exp=0", {busy, done, sum, cout, overflow});
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    total++;
    if (ndone !== 0 || sum !== '0) begin
      bad++; $display("FAIL abort_no_done got=%0d/%h exp=0/00", ndone, sum);
    end
  endtask

  task automatic test_random;
    logic [W+1:0] r, e; int lat; logic b1, ch;
    logic [W-1:0] ra, rb; logic rc, rs;
    for (int k = 0; k < 16; k++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      exp_q.push_back(model(W, int'(ra), int'(rb), int'(rc), int'(rs)));
      run_op(ra, rb, rc, rs, r, lat, b1, ch);
      e = exp_q.pop_front();
      total++;
      if (r !== e || lat !== 8 || ch !== 1'b0) begin
        bad++;
        $display("FAIL random_op a=%h b=%h cin=%b sub=%b got=%h lat=%0d chg=%b exp=%h lat=8 chg=0",
                 ra, rb, rc, rs, r, lat, ch, e);
      end
    end
  endtask

  task automatic test_sweep_w2;
    logic [3:0] r, e4; logic [W+1:0] e; int lat;
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++)
          for (int is = 0; is < 2; is++) begin
            run_op2(2'(ia), 2'(ib), 1'(ic), 1'(is), r, lat);
            e = model(2, ia, ib, ic, is);
            e4 = e[3:0];
            total++;
            if (r !== e4 || lat !== 2) begin
              bad++;
              $display("FAIL sweep_w2 a=%0d b=%0d cin=%0d sub=%0d got=%h lat=%0d exp=%h lat=2",
                       ia, ib, ic, is, r, lat, e4);
            end
          end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add_basic();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    test_sweep_w2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
